// File: rtl/substitui_bytes_iterativo.sv
// Iterative AES SubBytes / InvSubBytes engine for a 128-bit state.
// BYTES_POR_CICLO S-box copies work on the low bytes of a rotating work
// register. After 16/BYTES_POR_CICLO steps every byte has been substituted
// and the register is back in its original byte order.
module substitui_bytes_iterativo #(
    parameter int BYTES_POR_CICLO = 4,
    parameter int SUPORTA_INVERSA = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         entrada_valida,
    output logic         entrada_pronta,
    input  logic [127:0] bloco,
    input  logic         inversa,
    output logic         saida_valida,
    input  logic         saida_pronta,
    output logic [127:0] saida,
    output logic         ocupado
);
    localparam int B             = BYTES_POR_CICLO;
    localparam int PASSOS        = 16 / B;
    localparam int LARGURA_FATIA = 8 * B;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        PROCESSANDO = 2'd1,
        CONCLUIDO   = 2'd2
    } estado_t;

    if (B != 1 && B != 2 && B != 4 && B != 8 && B != 16) begin : g_parametro_invalido
        $error("BYTES_POR_CICLO must be 1, 2, 4, 8 or 16");
    end

    // Rotate a byte left by n positions.
    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] quad;
        logic [7:0] acc;
        quad = x;
        acc  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            quad = gf_mul(quad, quad);
            acc  = gf_mul(acc, quad);
        end
        return acc;
    endfunction

    // Forward S-box: field inverse followed by the affine transform.
    function automatic logic [7:0] sbox_direta(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the field inverse.
    function automatic logic [7:0] sbox_inversa(input logic [7:0] s);
        return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    estado_t        estado_q, estado_d;
    logic [4:0]     passo_q, passo_d;
    logic [127:0]   trabalho_q, trabalho_d;
    logic           modo_q, modo_d;
    logic [127:0]   saida_q, saida_d;
    logic           saida_valida_q, saida_valida_d;
    logic           ocupado_q, ocupado_d;

    logic [LARGURA_FATIA-1:0] fatia_sub_s;
    logic [127:0]             trabalho_rot_s;
    logic                     aceita_s;

    // One S-box (plus optional inverse) per byte of the low slice.
    for (genvar j = 0; j < B; j++) begin : g_sbox
        logic [7:0] direto_s;
        assign direto_s = sbox_direta(trabalho_q[8*j +: 8]);
        if (SUPORTA_INVERSA != 0) begin : g_com_inversa
            logic [7:0] inverso_s;
            assign inverso_s = sbox_inversa(trabalho_q[8*j +: 8]);
            assign fatia_sub_s[8*j +: 8] = modo_q ? inverso_s : direto_s;
        end else begin : g_so_direta
            assign fatia_sub_s[8*j +: 8] = direto_s;
        end
    end

    // Substituted slice goes to the top; the next unprocessed bytes drop to the bottom.
    if (B == 16) begin : g_rot_total
        assign trabalho_rot_s = fatia_sub_s;
    end else begin : g_rot_parcial
        assign trabalho_rot_s = {fatia_sub_s, trabalho_q[127:LARGURA_FATIA]};
    end

    assign entrada_pronta = (estado_q == OCIOSO) ||
                            ((estado_q == CONCLUIDO) && saida_pronta);
    assign aceita_s       = entrada_valida && entrada_pronta;

    // Next-state and datapath update for the three-state controller.
    always_comb begin
        estado_d       = estado_q;
        passo_d        = passo_q;
        trabalho_d     = trabalho_q;
        modo_d         = modo_q;
        saida_d        = saida_q;
        saida_valida_d = saida_valida_q;
        case (estado_q)
            OCIOSO: begin
                if (aceita_s) begin
                    trabalho_d = bloco;
                    modo_d     = (SUPORTA_INVERSA != 0) ? inversa : 1'b0;
                    passo_d    = 5'd0;
                    estado_d   = PROCESSANDO;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            PROCESSANDO: begin
                trabalho_d = trabalho_rot_s;
                if (passo_q == 5'(PASSOS - 1)) begin
                    saida_d        = trabalho_rot_s;
                    saida_valida_d = 1'b1;
                    passo_d        = 5'd0;
                    estado_d       = CONCLUIDO;
                end else begin
                    passo_d = passo_q + 5'd1;
                end
            end
            CONCLUIDO: begin
                if (saida_pronta) begin
                    saida_valida_d = 1'b0;
                    if (aceita_s) begin
                        trabalho_d = bloco;
                        modo_d     = (SUPORTA_INVERSA != 0) ? inversa : 1'b0;
                        passo_d    = 5'd0;
                        estado_d   = PROCESSANDO;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end else begin
                    estado_d = CONCLUIDO;
                end
            end
            default: begin
                estado_d       = OCIOSO;
                passo_d        = 5'd0;
                saida_valida_d = 1'b0;
            end
        endcase
        ocupado_d = (estado_d != OCIOSO);
    end

    // State registers with synchronous reset that aborts any block in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            passo_q        <= 5'd0;
            trabalho_q     <= 128'd0;
            modo_q         <= 1'b0;
            saida_q        <= 128'd0;
            saida_valida_q <= 1'b0;
            ocupado_q      <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            passo_q        <= passo_d;
            trabalho_q     <= trabalho_d;
            modo_q         <= modo_d;
            saida_q        <= saida_d;
            saida_valida_q <= saida_valida_d;
            ocupado_q      <= ocupado_d;
        end
    end

    assign saida        = saida_q;
    assign saida_valida = saida_valida_q;
    assign ocupado      = ocupado_q;

endmodule

// File: tb/tb_substitui_bytes_iterativo.sv
// Bench for substitui_bytes_iterativo: four instances (B=4, 1, 16 with
// inverse support, B=8 forward only) share one stimulus stream.
module tb_substitui_bytes_iterativo;
    localparam int ND = 4;
    localparam int INV_DUT [ND] = '{1, 1, 1, 0};
    localparam int LAT_ESP [ND] = '{5, 17, 2, 3};

    logic           clock;
    logic           reset;
    logic           entrada_valida;
    logic [127:0]   bloco;
    logic           inversa;
    logic           saida_pronta;
    logic [ND-1:0]  ep;
    logic [ND-1:0]  sv;
    logic [ND-1:0]  oc;
    logic [127:0]   so [ND];

    int total;
    int bad;

    logic [7:0]     tab_dir [256];
    logic [7:0]     tab_inv [256];
    logic [127:0]   esp_dut [ND];
    logic [127:0]   fila [ND][$];
    logic           seg_sv [ND];
    logic [127:0]   seg_so [ND];
    int             concl0;

    typedef struct {
        logic [127:0] bloco;
        logic         inv;
        logic [127:0] esp;
    } vetor_t;
    vetor_t vet [6];

    substitui_bytes_iterativo #(.BYTES_POR_CICLO(4), .SUPORTA_INVERSA(1)) u_d0 (
        .clock(clock), .reset(reset), .entrada_valida(entrada_valida),
        .entrada_pronta(ep[0]), .bloco(bloco), .inversa(inversa),
        .saida_valida(sv[0]), .saida_pronta(saida_pronta), .saida(so[0]), .ocupado(oc[0]));
    substitui_bytes_iterativo #(.BYTES_POR_CICLO(1), .SUPORTA_INVERSA(1)) u_d1 (
        .clock(clock), .reset(reset), .entrada_valida(entrada_valida),
        .entrada_pronta(ep[1]), .bloco(bloco), .inversa(inversa),
        .saida_valida(sv[1]), .saida_pronta(saida_pronta), .saida(so[1]), .ocupado(oc[1]));
    substitui_bytes_iterativo #(.BYTES_POR_CICLO(16), .SUPORTA_INVERSA(1)) u_d2 (
        .clock(clock), .reset(reset), .entrada_valida(entrada_valida),
        .entrada_pronta(ep[2]), .bloco(bloco), .inversa(inversa),
        .saida_valida(sv[2]), .saida_pronta(saida_pronta), .saida(so[2]), .ocupado(oc[2]));
    substitui_bytes_iterativo #(.BYTES_POR_CICLO(8), .SUPORTA_INVERSA(0)) u_d3 (
        .clock(clock), .reset(reset), .entrada_valida(entrada_valida),
        .entrada_pronta(ep[3]), .bloco(bloco), .inversa(inversa),
        .saida_valida(sv[3]), .saida_pronta(saida_pronta), .saida(so[3]), .ocupado(oc[3]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string nome, input logic [127:0] obtido,
                            input logic [127:0] esperado);
        total++;
        if (obtido !== esperado) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nome, obtido, esperado);
        end
    endtask

    function automatic int rol8(input int x, input int s);
        return ((x << s) | (x >> (8 - s))) & 32'hff;
    endfunction

    // Build the S-box by walking the multiplicative group with generator 3.
    task automatic monta_tabelas();
        int p;
        int q;
        int x;
        p = 1;
        q = 1;
        do begin
            p = (p ^ (p << 1) ^ (((p & 32'h80) != 0) ? 32'h1b : 32'h0)) & 32'hff;
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            q = q & 32'hff;
            if ((q & 32'h80) != 0) q = q ^ 32'h09;
            x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
            tab_dir[p] = 8'(x ^ 32'h63);
        end while (p != 1);
        tab_dir[0] = 8'h63;
        for (int i = 0; i < 256; i++) tab_inv[tab_dir[i]] = 8'(i);
    endtask

    function automatic logic [127:0] modelo(input logic [127:0] b, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = inv ? tab_inv[b[8*i +: 8]] : tab_dir[b[8*i +: 8]];
        return r;
    endfunction

    task automatic define_esperado(input vetor_t v);
        for (int d = 0; d < ND; d++)
            esp_dut[d] = (v.inv && INV_DUT[d] == 0) ? modelo(v.bloco, 1'b0) : v.esp;
    endtask

    // Present a block to every instance; returns #1 after the accepting edge.
    task automatic inicia_bloco(input logic [127:0] b, input logic inv, input logic sp);
        @(negedge clock);
        entrada_valida = 1'b1;
        bloco          = b;
        inversa        = inv;
        saida_pronta   = sp;
        #1;
        verifica("entrada_pronta before accept", 128'(ep), 128'(4'hf));
        @(posedge clock);
        #1;
        entrada_valida = 1'b0;
        saida_pronta   = 1'b0;
    endtask

    // Count cycles to completion per instance while junk input is offered.
    task automatic espera_conclusao();
        int  lat [ND];
        int  n;
        bit  todos;
        for (int d = 0; d < ND; d++) lat[d] = 0;
        n = 1;
        todos = 1'b0;
        entrada_valida = 1'b1;
        inversa = 1'b1;
        bloco = {$urandom(), $urandom(), $urandom(), $urandom()};
        while (n <= 40 && !todos) begin
            todos = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (lat[d] == 0) begin
                    if (sv[d]) lat[d] = n;
                    else verifica($sformatf("entrada_pronta busy d%0d", d), 128'(ep[d]), 128'd0);
                end
                if (lat[d] == 0) todos = 1'b0;
            end
            if (!todos) begin
                @(posedge clock);
                #1;
                n++;
            end
        end
        entrada_valida = 1'b0;
        for (int d = 0; d < ND; d++) begin
            verifica($sformatf("latency d%0d", d), 128'(lat[d]), 128'(LAT_ESP[d]));
            verifica($sformatf("saida d%0d", d), so[d], esp_dut[d]);
            verifica($sformatf("ocupado done d%0d", d), 128'(oc[d]), 128'd1);
        end
    endtask

    task automatic libera();
        @(negedge clock);
        entrada_valida = 1'b0;
        saida_pronta   = 1'b1;
        @(posedge clock);
        #1;
        saida_pronta = 1'b0;
        verifica("saida_valida after release", 128'(sv), 128'd0);
        verifica("ocupado after release", 128'(oc), 128'd0);
    endtask

    // One random streaming cycle with scoreboard and stability checks.
    task automatic passo_aleatorio(input bit ativo);
        @(negedge clock);
        entrada_valida = ativo ? ($urandom_range(0, 99) < 60) : 1'b0;
        bloco          = {$urandom(), $urandom(), $urandom(), $urandom()};
        inversa        = 1'($urandom_range(0, 1));
        saida_pronta   = ativo ? ($urandom_range(0, 99) < 60) : 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            if (seg_sv[d]) begin
                verifica($sformatf("stable saida d%0d", d), so[d], seg_so[d]);
                verifica($sformatf("stable valida d%0d", d), 128'(sv[d]), 128'd1);
            end
            if (entrada_valida && ep[d])
                fila[d].push_back(modelo(bloco, inversa && (INV_DUT[d] != 0)));
            if (sv[d] && saida_pronta) begin
                if (fila[d].size() == 0) begin
                    verifica($sformatf("duplicate d%0d", d), 128'd1, 128'd0);
                end else begin
                    verifica($sformatf("stream d%0d", d), so[d], fila[d].pop_front());
                end
                seg_sv[d] = 1'b0;
                if (d == 0) concl0++;
            end else begin
                seg_sv[d] = sv[d];
                seg_so[d] = so[d];
            end
        end
    endtask

    initial begin
        logic [127:0] salvo [ND];
        int ciclos;
        total = 0;
        bad = 0;
        monta_tabelas();
        vet[0] = '{128'd0, 1'b0, {16{8'h63}}};
        vet[1] = '{128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                   128'h76abd7fe2b670130c56f6bf27b777c63};
        vet[2] = '{128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1,
                   128'h0f0e0d0c0b0a09080706050403020100};
        vet[3] = '{{16{8'hff}}, 1'b0, {16{8'h16}}};
        vet[4] = '{{16{8'h16}}, 1'b1, {16{8'hff}}};
        vet[5] = '{128'd0, 1'b1, {16{8'h52}}};

        reset = 1'b1;
        entrada_valida = 1'b0;
        saida_pronta = 1'b0;
        bloco = 128'd0;
        inversa = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        verifica("reset entrada_pronta", 128'(ep), 128'(4'hf));
        verifica("reset saida_valida", 128'(sv), 128'd0);
        verifica("reset ocupado", 128'(oc), 128'd0);
        for (int d = 0; d < ND; d++) verifica($sformatf("reset saida d%0d", d), so[d], 128'd0);

        // Table-driven known-answer vectors.
        for (int v = 0; v < 6; v++) begin
            define_esperado(vet[v]);
            inicia_bloco(vet[v].bloco, vet[v].inv, 1'b0);
            espera_conclusao();
            libera();
        end

        // Backpressure for 10 cycles, then release together with a new block.
        define_esperado(vet[1]);
        inicia_bloco(vet[1].bloco, 1'b0, 1'b0);
        espera_conclusao();
        for (int d = 0; d < ND; d++) salvo[d] = so[d];
        repeat (10) begin
            @(posedge clock);
            #1;
            verifica("backpressure entrada_pronta", 128'(ep), 128'd0);
            verifica("backpressure saida_valida", 128'(sv), 128'(4'hf));
            for (int d = 0; d < ND; d++)
                verifica($sformatf("backpressure saida d%0d", d), so[d], salvo[d]);
        end
        define_esperado(vet[2]);
        inicia_bloco(vet[2].bloco, 1'b1, 1'b1);
        verifica("back-to-back saida_valida", 128'(sv), 128'd0);
        verifica("back-to-back ocupado", 128'(oc), 128'(4'hf));
        espera_conclusao();
        libera();

        // Reset two steps into processing aborts without emitting anything.
        inicia_bloco(vet[1].bloco, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        verifica("abort saida_valida", 128'(sv), 128'd0);
        verifica("abort ocupado", 128'(oc), 128'd0);
        verifica("abort entrada_pronta", 128'(ep), 128'(4'hf));
        for (int d = 0; d < ND; d++) verifica($sformatf("abort saida d%0d", d), so[d], 128'd0);
        @(negedge clock);
        reset = 1'b0;
        define_esperado(vet[2]);
        inicia_bloco(vet[2].bloco, 1'b1, 1'b0);
        espera_conclusao();
        libera();

        // Reset coincident with an input handshake: no transfer.
        @(negedge clock);
        reset = 1'b1;
        entrada_valida = 1'b1;
        bloco = vet[1].bloco;
        @(posedge clock);
        #1;
        verifica("reset vs accept ocupado", 128'(oc), 128'd0);
        @(negedge clock);
        reset = 1'b0;
        entrada_valida = 1'b0;
        @(posedge clock);
        #1;
        verifica("reset vs accept idle", 128'(oc), 128'd0);

        // Random streaming with scoreboard.
        for (int d = 0; d < ND; d++) seg_sv[d] = 1'b0;
        concl0 = 0;
        ciclos = 0;
        while (concl0 < 1000 && ciclos < 30000) begin
            passo_aleatorio(1'b1);
            ciclos++;
        end
        verifica("stream blocks completed", 128'(concl0 >= 1000), 128'd1);
        repeat (40) passo_aleatorio(1'b0);
        for (int d = 0; d < ND; d++)
            verifica($sformatf("stream lost d%0d", d), 128'(fila[d].size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
